pc_seq_ctrl: RTL and testbench

- Next-PC sequencer for the 5-stage MIPS pipeline. Owns the architectural fetch PC register.
- Arbitrates between sequential fetch, load-use stall, ID-stage branch, J-type jump and jr redirects.
- Generates the IF/ID flush and PC-enable strobes.
- Sits between the hazard unit / ID-stage decode and the instruction memory address port.

---
 rtl/pc_seq_pkg.sv | 36 +++
 rtl/sat_counter.sv | 48 ++++
 rtl/pc_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the next-PC sequencer:
//               FSM state encoding, default reset fetch address and the
//               next-PC select codes used by the priority mux.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  // Encoding 2'd3 is never entered; the FSM decodes it back to BOOT.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_JR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_BR   = 3'd4
  } pc_sel_e;

  // J-type target: region bits of the ID-stage PC, word index, word aligned.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc_region,
                                              input logic [25:0] idx);
    return {pc_region, idx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk_i   - clock, rising edge
//               rst_ni  - asynchronous active-low reset (count -> 0)
//               clr_i   - synchronous clear, dominates inc_i
//               inc_i   - increment request for this cycle
//               cnt_o   - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Next-PC sequencer for the 5-stage MIPS pipeline. Owns the
//               fetch PC and arbitrates stall > jr > jump > branch > pc+4.
//               Redirects squash the wrong-path fetch via if_flush_o and may
//               extend the squash through a FLUSH state.
// Ports       : clk_i, rst_ni     - clock / async active-low reset
//               stall_i           - load-use hazard, hold PC
//               br_taken_i/br_target_i, jump_i/jump_idx_i,
//               jr_i/jr_target_i  - ID-stage redirect requests
//               pc_id_i           - PC of the instruction in ID
//               pc_o, pc_plus4_o  - fetch address and its successor
//               pc_en_o, if_flush_o - PC update / IF-ID clear strobes
//               state_o           - FSM state (debug)
//               stall_cnt_o, redir_cnt_o - saturating perf counters
//               addr_err_o        - sticky misaligned-target flag
//                                   (only with PC_ALIGN_CHK_EN)
// Config      : `define PC_ALIGN_CHK_EN to reject misaligned jr/branch
//               targets; otherwise the low two target bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_idx_i,
  input  logic             jr_i,
  input  logic [31:0]      jr_target_i,
  input  logic [31:0]      pc_id_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             pc_en_o,
  output logic             if_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic             addr_err_o
`endif
);

  // Extra squash cycles spent in FLUSH after the redirect cycle itself.
  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam bit         HAS_FLUSH = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  pc_sel_e     sel;
  pc_sel_e     redir_sel;
  logic [31:0] jr_tgt, br_tgt, j_tgt;
  logic        redir_req;
  logic        redir_ok;
  logic        stall_inc;
  logic        redir_inc;
  logic        addr_err_set;

  assign pc_plus4  = pc_q + 32'd4;
  assign j_tgt     = jump_target(pc_id_i[31:28], jump_idx_i);
  assign redir_req = jr_i | jump_i | br_taken_i;

  always_comb begin
    redir_sel = SEL_BR;
    if (jr_i) begin
      redir_sel = SEL_JR;
    end else if (jump_i) begin
      redir_sel = SEL_J;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic [31:0] redir_tgt;
  logic        addr_err_q;

  assign jr_tgt = jr_target_i;
  assign br_tgt = br_target_i;

  always_comb begin
    redir_tgt = br_tgt;
    if (jr_i) begin
      redir_tgt = jr_tgt;
    end else if (jump_i) begin
      redir_tgt = j_tgt;
    end
  end

  // Only the winning target is checked; jump targets are always aligned.
  assign redir_ok = (redir_tgt[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_err_q <= 1'b0;
    end else if (addr_err_set) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err_o = addr_err_q;

  logic unused_w;
  assign unused_w = ^pc_id_i[27:0];
`else
  assign jr_tgt   = {jr_target_i[31:2], 2'b00};
  assign br_tgt   = {br_target_i[31:2], 2'b00};
  assign redir_ok = 1'b1;

  logic unused_w;
  assign unused_w = ^{pc_id_i[27:0], jr_target_i[1:0], br_target_i[1:0],
                      addr_err_set};
`endif

  // Next-state and strobe logic. Strobes depend on the current inputs so the
  // IF/ID register sees if_flush in the same cycle the redirect is decoded.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    sel          = SEL_HOLD;
    pc_en_o      = 1'b0;
    if_flush_o   = 1'b0;
    stall_inc    = 1'b0;
    redir_inc    = 1'b0;
    addr_err_set = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (stall_i) begin
          // Redirects seen under a stall are re-presented by the hazard unit.
          stall_inc = 1'b1;
        end else if (redir_req) begin
          if_flush_o = 1'b1;
          if (redir_ok) begin
            sel       = redir_sel;
            pc_en_o   = 1'b1;
            redir_inc = 1'b1;
            if (HAS_FLUSH) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_INIT;
            end
          end else begin
            addr_err_set = 1'b1;
          end
        end else begin
          sel     = SEL_SEQ;
          pc_en_o = 1'b1;
        end
      end
      FLUSH: begin
        // Everything arriving from ID now belongs to squashed instructions.
        if_flush_o = 1'b1;
        sel        = SEL_SEQ;
        pc_en_o    = 1'b1;
        fcnt_d     = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    case (sel)
      SEL_SEQ: pc_d = pc_plus4;
      SEL_JR:  pc_d = jr_tgt;
      SEL_J:   pc_d = j_tgt;
      SEL_BR:  pc_d = br_tgt;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      fcnt_q  <= 3'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (redir_inc),
    .cnt_o  (redir_cnt_o)
  );

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq_ctrl
// Description : Self-checking bench for pc_seq_ctrl. Instance 0 uses the
//               default parameters, instance 1 uses FLUSH_CYCLES=3 and a
//               3-bit counter width so saturation is reachable quickly.
//               A behavioural model predicts every output each cycle, and
//               directed steps pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall[2], br[2], jump[2], jr[2];
  logic [31:0] br_t[2], jr_t[2], pc_id[2];
  logic [25:0] jidx[2];

  logic [31:0] d_pc[2], d_pp4[2];
  logic        d_en[2], d_fl[2];
  logic [1:0]  d_st[2];
  logic [15:0] d_sc0, d_rc0;
  logic [2:0]  d_sc1, d_rc1;
`ifdef PC_ALIGN_CHK_EN
  logic        d_err[2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_seq_ctrl #(.RESET_PC(32'h0000_3000), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[0]),
    .br_taken_i(br[0]), .br_target_i(br_t[0]),
    .jump_i(jump[0]), .jump_idx_i(jidx[0]),
    .jr_i(jr[0]), .jr_target_i(jr_t[0]), .pc_id_i(pc_id[0]),
    .pc_o(d_pc[0]), .pc_plus4_o(d_pp4[0]), .pc_en_o(d_en[0]),
    .if_flush_o(d_fl[0]), .state_o(d_st[0]),
    .stall_cnt_o(d_sc0), .redir_cnt_o(d_rc0)
`ifdef PC_ALIGN_CHK_EN
    , .addr_err_o(d_err[0])
`endif
  );

  pc_seq_ctrl #(.RESET_PC(32'h0000_3000), .FLUSH_CYCLES(3), .CNT_W(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[1]),
    .br_taken_i(br[1]), .br_target_i(br_t[1]),
    .jump_i(jump[1]), .jump_idx_i(jidx[1]),
    .jr_i(jr[1]), .jr_target_i(jr_t[1]), .pc_id_i(pc_id[1]),
    .pc_o(d_pc[1]), .pc_plus4_o(d_pp4[1]), .pc_en_o(d_en[1]),
    .if_flush_o(d_fl[1]), .state_o(d_st[1]),
    .stall_cnt_o(d_sc1), .redir_cnt_o(d_rc1)
`ifdef PC_ALIGN_CHK_EN
    , .addr_err_o(d_err[1])
`endif
  );

  // ---------------------------------------------------------------- model --
  logic [31:0] m_pc[2];
  logic        m_boot[2];
  int          m_fl[2];     // squash cycles still owed after a redirect
  int          m_sc[2], m_rc[2];
  logic        m_err[2];

  function automatic int fcyc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  typedef struct packed {
    logic        en;
    logic        fl;
    logic [31:0] npc;
    logic        sinc;
    logic        rinc;
    logic        err;
  } exp_t;

  function automatic exp_t model_eval(input int k);
    exp_t        e;
    logic [31:0] tgt;
    e     = '0;
    e.npc = m_pc[k];
    if (m_boot[k]) begin
      e.en = 1'b0;
    end else if (m_fl[k] > 0) begin
      e.fl  = 1'b1;
      e.en  = 1'b1;
      e.npc = m_pc[k] + 32'd4;
    end else if (stall[k]) begin
      e.sinc = 1'b1;
    end else if (jr[k] || jump[k] || br[k]) begin
      if (jr[k])        tgt = jr_t[k];
      else if (jump[k]) tgt = {pc_id[k][31:28], jidx[k], 2'b00};
      else              tgt = br_t[k];
      e.fl = 1'b1;
`ifdef PC_ALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) begin
        e.err = 1'b1;
      end else begin
        e.en = 1'b1; e.npc = tgt; e.rinc = 1'b1;
      end
`else
      tgt[1:0] = 2'b00;
      e.en = 1'b1; e.npc = tgt; e.rinc = 1'b1;
`endif
    end else begin
      e.en  = 1'b1;
      e.npc = m_pc[k] + 32'd4;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pc[k] <= 32'h0000_3000; m_boot[k] <= 1'b1; m_fl[k] <= 0;
        m_sc[k] <= 0; m_rc[k] <= 0; m_err[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e = model_eval(k);
        m_pc[k]   <= e.npc;
        m_boot[k] <= 1'b0;
        if (e.rinc)        m_fl[k] <= fcyc(k) - 1;
        else if (m_fl[k] > 0) m_fl[k] <= m_fl[k] - 1;
        if (e.sinc && m_sc[k] < cmax(k)) m_sc[k] <= m_sc[k] + 1;
        if (e.rinc && m_rc[k] < cmax(k)) m_rc[k] <= m_rc[k] + 1;
        if (e.err) m_err[k] <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t        e;
      logic [31:0] sc, rc;
      e  = model_eval(k);
      sc = (k == 0) ? 32'(d_sc0) : 32'(d_sc1);
      rc = (k == 0) ? 32'(d_rc0) : 32'(d_rc1);
      check($sformatf("m_pc%0d", k), d_pc[k], m_pc[k]);
      check($sformatf("m_pp4_%0d", k), d_pp4[k], m_pc[k] + 32'd4);
      check($sformatf("m_en%0d", k), 32'(d_en[k]), 32'(e.en));
      check($sformatf("m_flush%0d", k), 32'(d_fl[k]), 32'(e.fl));
      check($sformatf("m_state%0d", k), 32'(d_st[k]),
            m_boot[k] ? 32'd0 : (m_fl[k] > 0 ? 32'd2 : 32'd1));
      check($sformatf("m_stallcnt%0d", k), sc, 32'(m_sc[k]));
      check($sformatf("m_redircnt%0d", k), rc, 32'(m_rc[k]));
`ifdef PC_ALIGN_CHK_EN
      check($sformatf("m_err%0d", k), 32'(d_err[k]), 32'(m_err[k]));
`endif
    end
  end

  // ------------------------------------------------------------- stimulus --
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in(input int k);
    stall[k] = 1'b0; br[k] = 1'b0; jump[k] = 1'b0; jr[k] = 1'b0;
    br_t[k] = '0; jr_t[k] = '0; pc_id[k] = '0; jidx[k] = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in(0);
    clr_in(1);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("boot_pc", d_pc[0], 32'h3000);
    check("boot_en", 32'(d_en[0]), 32'd0);
    check("boot_state", 32'(d_st[0]), 32'd0);
    step();
    check("run_state", 32'(d_st[0]), 32'd1);
    check("run_pc_hold", d_pc[0], 32'h3000);
    check("run_en", 32'(d_en[0]), 32'd1);
    step(); check("seq_3004", d_pc[0], 32'h3004);
    step(); check("seq_3008", d_pc[0], 32'h3008);
    step();
    step(); check("seq_3010", d_pc[0], 32'h3010);

    // J-type redirect
    jump[0] = 1'b1; pc_id[0] = 32'h4000_0100; jidx[0] = 26'h0000040;
    #1; check("jump_flush", 32'(d_fl[0]), 32'd1);
    step();
    clr_in(0);
    check("jump_pc", d_pc[0], 32'h4000_0100);
    check("jump_redir", 32'(d_rc0), 32'd1);
    #1; check("jump_flush_once", 32'(d_fl[0]), 32'd0);

    // stall with a pending branch held the whole time
    stall[0] = 1'b1; br[0] = 1'b1; br_t[0] = 32'h5000;
    #1; check("stall_noflush", 32'(d_fl[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc_frozen", d_pc[0], 32'h4000_0100);
    end
    check("stall_cnt3", 32'(d_sc0), 32'd3);
    check("stall_redir", 32'(d_rc0), 32'd1);
    stall[0] = 1'b0;
    #1; check("br_flush", 32'(d_fl[0]), 32'd1);
    step();
    clr_in(0);
    check("br_pc", d_pc[0], 32'h5000);
    check("br_redir", 32'(d_rc0), 32'd2);

    // simultaneous jr + jump + branch
    jr[0] = 1'b1; jr_t[0] = 32'h6000;
    jump[0] = 1'b1; pc_id[0] = 32'h9000_0000; jidx[0] = 26'h1;
    br[0] = 1'b1; br_t[0] = 32'hA000;
    step();
    clr_in(0);
    check("jr_prio_pc", d_pc[0], 32'h6000);
    check("jr_prio_redir", 32'(d_rc0), 32'd3);

    // misaligned jr target
    jr[0] = 1'b1; jr_t[0] = 32'h8002;
    step();
    clr_in(0);
`ifdef PC_ALIGN_CHK_EN
    check("align_pc_hold", d_pc[0], 32'h6000);
    check("align_err", 32'(d_err[0]), 32'd1);
    check("align_redir", 32'(d_rc0), 32'd3);
    step();
    check("align_err_sticky", 32'(d_err[0]), 32'd1);
    check("align_seq", d_pc[0], 32'h6004);
`else
    check("align_pc_forced", d_pc[0], 32'h8000);
    check("align_redir", 32'(d_rc0), 32'd4);
`endif

    // wrap-around at the top of the address space
    jr[0] = 1'b1; jr_t[0] = 32'hFFFF_FFFC;
    step();
    clr_in(0);
    check("wrap_pc", d_pc[0], 32'hFFFF_FFFC);
    check("wrap_pp4", d_pp4[0], 32'h0);
    step();
    check("wrap_pc0", d_pc[0], 32'h0);

    // FLUSH_CYCLES=3 instance: branch pulses during FLUSH are ignored
    br[1] = 1'b1; br_t[1] = 32'h7000;
    #1; check("f3_flush0", 32'(d_fl[1]), 32'd1);
    step();
    br_t[1] = 32'h9000;
    check("f3_pc7000", d_pc[1], 32'h7000);
    check("f3_state_flush", 32'(d_st[1]), 32'd2);
    #1; check("f3_flush1", 32'(d_fl[1]), 32'd1);
    step();
    check("f3_pc7004", d_pc[1], 32'h7004);
    check("f3_flush2", 32'(d_fl[1]), 32'd1);
    step();
    br[1] = 1'b0;
    check("f3_pc7008", d_pc[1], 32'h7008);
    check("f3_state_run", 32'(d_st[1]), 32'd1);
    check("f3_redir", 32'(d_rc1), 32'd1);
    #1; check("f3_flush_done", 32'(d_fl[1]), 32'd0);

    // counter saturation on the 3-bit instance
    stall[1] = 1'b1;
    repeat (10) step();
    check("sat_stall", 32'(d_sc1), 32'd7);
    stall[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      br[1] = 1'b1; br_t[1] = 32'h100;
      step();
      br[1] = 1'b0;
      step();
      step();
    end
    check("sat_redir", 32'(d_rc1), 32'd7);

    // asynchronous reset mid-stall (inst 0) and mid-FLUSH (inst 1)
    stall[0] = 1'b1;
    br[1] = 1'b1; br_t[1] = 32'h200;
    step();
    br[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_pc%0d", k), d_pc[k], 32'h3000);
      check($sformatf("rst_state%0d", k), 32'(d_st[k]), 32'd0);
      check($sformatf("rst_en%0d", k), 32'(d_en[k]), 32'd0);
      check($sformatf("rst_flush%0d", k), 32'(d_fl[k]), 32'd0);
    end
    check("rst_sc0", 32'(d_sc0), 32'd0);
    check("rst_rc1", 32'(d_rc1), 32'd0);
    step();
    stall[0] = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    step();
    check("rerun_pc", d_pc[0], 32'h3008);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
